hazard_forwarding_unit: RTL and testbench

- Consumes the per-instruction control signals produced by the decode-stage controller and turns them into pipeline-control actions.
- Tracks every in-flight register writer in EX, MEM and WB and compares it against the register reads of the instruction in decode.
- Drives a stall, forwarding selects for decode-stage consumers, and registered forwarding selects that travel with the instruction into EX and MEM.
- Sits beside the 5-stage datapath; the datapath muxes operands with its selects.

---
 rtl/hazard_forwarding_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_forwarding_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks writers in EX/MEM/WB, stalls decode on unresolved RAW hazards and routes forwarding selects.
module hazard_forwarding_unit #(
  parameter int unsigned REG_ID_WIDTH  = 5,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     decValid,
  input  logic [REG_ID_WIDTH-1:0]  decReadId1,
  input  logic [REG_ID_WIDTH-1:0]  decReadId2,
  input  logic [1:0]               decRequiredStage,
  input  logic                     decWriteEnabled,
  input  logic [REG_ID_WIDTH-1:0]  decWriteId,
  input  logic [1:0]               decWriteFrom,
  output logic                     stall,
  output logic [1:0]               fwdDecode1,
  output logic [1:0]               fwdDecode2,
  output logic [1:0]               fwdExec1,
  output logic [1:0]               fwdExec2,
  output logic [1:0]               fwdMem1,
  output logic [1:0]               fwdMem2,
  output logic [COUNTER_WIDTH-1:0] stallCount
);

  localparam logic [1:0] STAGE_DECODE = 2'd0;
  localparam logic [1:0] STAGE_EXEC   = 2'd1;
  localparam logic [1:0] STAGE_MEM    = 2'd2;
  localparam logic [1:0] STAGE_NONE   = 2'd3;

  localparam logic [1:0] FROM_ALU = 2'd0;
  localparam logic [1:0] FROM_DM  = 2'd1;

  typedef struct packed {
    logic                    valid;
    logic [REG_ID_WIDTH-1:0] id;
    logic [1:0]              avail;
  } wr_rec_t;

  wr_rec_t ex_q, mem_q, wb_q;
  wr_rec_t dec_rec;

  logic [1:0] fwd_exec1_q, fwd_exec2_q;
  logic [1:0] mem_pend1_q, mem_pend2_q;
  logic [1:0] fwd_mem1_q, fwd_mem2_q;
  logic [COUNTER_WIDTH-1:0] stall_count_q;

  logic       active;
  logic       hz1, hz2;
  logic [1:0] src1, src2;

  // Youngest-match lookup; returns {hazard, source} for one operand.
  function automatic logic [2:0] resolve(input logic [REG_ID_WIDTH-1:0] rid,
                                         input logic [1:0] req,
                                         input wr_rec_t ex, input wr_rec_t mem,
                                         input wr_rec_t wb);
    logic       hit;
    logic [1:0] p;
    logic [1:0] av;
    logic [2:0] sum;
    logic [2:0] res;
    hit = 1'b0;
    p   = 2'd0;
    av  = 2'd0;
    res = 3'd0;
    if (ex.valid && ex.id == rid) begin
      hit = 1'b1; p = 2'd1; av = ex.avail;
    end else if (mem.valid && mem.id == rid) begin
      hit = 1'b1; p = 2'd2; av = mem.avail;
    end else if (wb.valid && wb.id == rid) begin
      hit = 1'b1; p = 2'd3; av = wb.avail;
    end
    sum = 3'(p) + 3'(req);
    if (hit) begin
      if (sum < 3'(av))       res = 3'b100;
      else if (sum <= 3'd3)   res = {1'b0, sum[1:0]};
    end
    return res;
  endfunction

  always_comb begin
    active = decValid && (decRequiredStage != STAGE_NONE);
    hz1    = 1'b0;
    hz2    = 1'b0;
    src1   = 2'd0;
    src2   = 2'd0;
    if (active && decReadId1 != '0)
      {hz1, src1} = resolve(decReadId1, decRequiredStage, ex_q, mem_q, wb_q);
    if (active && decReadId2 != '0)
      {hz2, src2} = resolve(decReadId2, decRequiredStage, ex_q, mem_q, wb_q);
  end

  assign stall      = hz1 | hz2;
  assign fwdDecode1 = (decRequiredStage == STAGE_DECODE) ? src1 : 2'd0;
  assign fwdDecode2 = (decRequiredStage == STAGE_DECODE) ? src2 : 2'd0;

  // Result availability stage: ALU at MEM, load at WB, PC+8/imm already at EX.
  always_comb begin
    dec_rec.valid = active && decWriteEnabled && (decWriteId != '0);
    dec_rec.id    = decWriteId;
    unique case (decWriteFrom)
      FROM_ALU: dec_rec.avail = 2'd2;
      FROM_DM:  dec_rec.avail = 2'd3;
      default:  dec_rec.avail = 2'd1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      fwd_exec1_q   <= 2'd0;
      fwd_exec2_q   <= 2'd0;
      mem_pend1_q   <= 2'd0;
      mem_pend2_q   <= 2'd0;
      fwd_mem1_q    <= 2'd0;
      fwd_mem2_q    <= 2'd0;
      stall_count_q <= '0;
    end else begin
      wb_q       <= mem_q;
      mem_q      <= ex_q;
      fwd_mem1_q <= mem_pend1_q;
      fwd_mem2_q <= mem_pend2_q;
      if (stall) begin
        ex_q          <= '0;
        fwd_exec1_q   <= 2'd0;
        fwd_exec2_q   <= 2'd0;
        mem_pend1_q   <= 2'd0;
        mem_pend2_q   <= 2'd0;
        stall_count_q <= stall_count_q + COUNTER_WIDTH'(1);
      end else begin
        ex_q        <= dec_rec;
        fwd_exec1_q <= (decRequiredStage == STAGE_EXEC) ? src1 : 2'd0;
        fwd_exec2_q <= (decRequiredStage == STAGE_EXEC) ? src2 : 2'd0;
        mem_pend1_q <= (decRequiredStage == STAGE_MEM)  ? src1 : 2'd0;
        mem_pend2_q <= (decRequiredStage == STAGE_MEM)  ? src2 : 2'd0;
      end
    end
  end

  assign fwdExec1   = fwd_exec1_q;
  assign fwdExec2   = fwd_exec2_q;
  assign fwdMem1    = fwd_mem1_q;
  assign fwdMem2    = fwd_mem2_q;
  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed and random checking of hazard_forwarding_unit against a history-based pipeline model.
module tb_hazard_forwarding_unit;

  logic        clock = 1'b0;
  logic        resetN;
  logic        decValid;
  logic [4:0]  decReadId1, decReadId2, decWriteId;
  logic [1:0]  decRequiredStage, decWriteFrom;
  logic        decWriteEnabled;
  logic        stall;
  logic [1:0]  fwdDecode1, fwdDecode2, fwdExec1, fwdExec2, fwdMem1, fwdMem2;
  logic [31:0] stallCount;

  int nvec = 0;
  int nerr = 0;

  hazard_forwarding_unit #(.REG_ID_WIDTH(5), .COUNTER_WIDTH(32)) dut (
    .clock(clock), .resetN(resetN), .decValid(decValid),
    .decReadId1(decReadId1), .decReadId2(decReadId2),
    .decRequiredStage(decRequiredStage), .decWriteEnabled(decWriteEnabled),
    .decWriteId(decWriteId), .decWriteFrom(decWriteFrom),
    .stall(stall), .fwdDecode1(fwdDecode1), .fwdDecode2(fwdDecode2),
    .fwdExec1(fwdExec1), .fwdExec2(fwdExec2), .fwdMem1(fwdMem1), .fwdMem2(fwdMem2),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  // Model: the last three issue slots (index 0 = now in EX, 2 = now in WB).
  bit          h_v[3];
  int          h_id[3];
  int          h_av[3];
  int          m_exec[2], m_pend[2], m_mem[2];
  int unsigned m_cnt;
  bit          m_stall;
  int          m_src[2];

  function automatic int avail_of(int wf);
    case (wf)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin h_v[k] = 0; h_id[k] = 0; h_av[k] = 0; end
    for (int i = 0; i < 2; i++) begin m_exec[i] = 0; m_pend[i] = 0; m_mem[i] = 0; end
    m_cnt = 0;
  endtask

  // Producer at distance P reaches stage P+R when the consumer needs it.
  task automatic model_eval(input int rid, input int req, input bit act,
                            output bit hz, output int src);
    hz = 0; src = 0;
    if (!act || rid == 0) return;
    for (int k = 0; k < 3; k++) begin
      if (h_v[k] && h_id[k] == rid) begin
        if (k + 1 + req < h_av[k]) hz = 1;
        else if (k + 1 + req <= 3) src = k + 1 + req;
        return;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int r1, input int r2, input int req,
                      input bit we, input int wid, input int wf, input bit rstn);
    bit act, hz0, hz1;
    int s0, s1;
    resetN = rstn; decValid = v;
    decReadId1 = 5'(r1); decReadId2 = 5'(r2); decRequiredStage = 2'(req);
    decWriteEnabled = we; decWriteId = 5'(wid); decWriteFrom = 2'(wf);
    act = v && req != 3;
    model_eval(r1, req, act, hz0, s0);
    model_eval(r2, req, act, hz1, s1);
    m_stall = hz0 | hz1;
    m_src[0] = s0; m_src[1] = s1;
    @(negedge clock);
    chk("stall",      32'(stall),      32'(m_stall));
    chk("fwdDecode1", 32'(fwdDecode1), (req == 0) ? 32'(s0) : 32'd0);
    chk("fwdDecode2", 32'(fwdDecode2), (req == 0) ? 32'(s1) : 32'd0);
    chk("fwdExec1",   32'(fwdExec1),   32'(m_exec[0]));
    chk("fwdExec2",   32'(fwdExec2),   32'(m_exec[1]));
    chk("fwdMem1",    32'(fwdMem1),    32'(m_mem[0]));
    chk("fwdMem2",    32'(fwdMem2),    32'(m_mem[1]));
    chk("stallCount", stallCount,      m_cnt);
    @(posedge clock);
    if (!rstn) model_reset();
    else begin
      for (int k = 2; k > 0; k--) begin
        h_v[k] = h_v[k-1]; h_id[k] = h_id[k-1]; h_av[k] = h_av[k-1];
      end
      h_v[0]  = !m_stall && act && we && wid != 0;
      h_id[0] = wid;
      h_av[0] = avail_of(wf);
      for (int i = 0; i < 2; i++) begin
        m_mem[i]  = m_pend[i];
        m_exec[i] = (!m_stall && req == 1) ? m_src[i] : 0;
        m_pend[i] = (!m_stall && req == 2) ? m_src[i] : 0;
      end
      if (m_stall) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  // Shorthands: ALU op (R=1), load (R=1), branch (R=0), nop bubble.
  task automatic alu(input int rd, input int rs, input int rt); step(1, rs, rt, 1, 1, rd, 0, 1); endtask
  task automatic lw(input int rt, input int rs);                 step(1, rs, 0, 1, 1, rt, 1, 1); endtask
  task automatic beq(input int rs, input int rt);                step(1, rs, rt, 0, 0, 0, 0, 1); endtask
  task automatic nop();                                          step(0, 0, 0, 3, 0, 0, 0, 1); endtask

  initial begin
    resetN = 1'b0; decValid = 1'b0; decReadId1 = '0; decReadId2 = '0;
    decRequiredStage = 2'd3; decWriteEnabled = 1'b0; decWriteId = '0; decWriteFrom = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    nop(); nop();

    alu(3, 1, 2); alu(4, 3, 3); nop(); nop(); nop();
    lw(5, 1); alu(6, 5, 0); alu(6, 5, 0); nop(); nop(); nop();
    alu(7, 1, 2); beq(7, 0); beq(7, 0); nop(); nop(); nop();
    lw(7, 1); beq(7, 0); beq(7, 0); beq(7, 0); nop(); nop(); nop();
    lw(8, 1); step(1, 9, 8, 2, 0, 0, 0, 1); nop(); nop(); nop();
    step(1, 0, 0, 0, 1, 31, 2, 1); step(1, 31, 0, 0, 0, 0, 0, 1); nop(); nop(); nop();
    alu(0, 1, 2); beq(0, 0); nop(); nop(); nop();
    alu(3, 1, 2); alu(3, 4, 5); alu(9, 3, 0); nop(); nop(); nop();
    step(1, 0, 0, 3, 1, 10, 0, 1); alu(11, 10, 0); nop(); nop(); nop();
    lw(5, 1); step(1, 5, 0, 1, 1, 6, 0, 0); alu(6, 5, 0); nop(); nop(); nop();

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 3), ($urandom_range(0, 49) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
